// File: rtl/mp_link_pkg.sv
// Shared types and constants for the two-board multiplayer serial link.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
package mp_link_pkg;

    localparam int MP_PAYLOAD_BITS     = 6;
    // Frame lengths in bit times: start + payload + [parity] + stop.
    localparam int MP_FRAME_BITS_PAR   = MP_PAYLOAD_BITS + 3;
    localparam int MP_FRAME_BITS_NOPAR = MP_PAYLOAD_BITS + 2;

    // Bit 0 is pause, bit 1 is reload, bits 5:2 are score.
    typedef struct packed {
        logic [3:0] score;
        logic       reload;
        logic       pause;
    } mp_payload_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } mp_state_t;

    // XOR of the payload; makes payload + parity bit even.
    function automatic logic mp_parity(input mp_payload_t p);
        return ^p;
    endfunction

endpackage

// File: rtl/mp_link_bit_timer.sv
// Bit-time down-counter: emits bit_end on the last cycle of every bit time.
// Latency: first bit_end CLKS_PER_BIT cycles after the start load.
// Backpressure: none; runs freely while i_run is high.
// Ports: clk/rst (sync active-high), i_start loads a fresh bit time,
//        i_run enables counting, o_bit_end marks the last cycle of a bit,
//        o_bit_pre_end marks the cycle before it (CLKS_PER_BIT >= 2).
module mp_link_bit_timer #(
    parameter int CLKS_PER_BIT = 564
) (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    input  logic i_run,
    output logic o_bit_end,
    output logic o_bit_pre_end
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LOAD = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_cnt;

    // Reload on the terminal count so consecutive bits chain with no gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_start || (i_run && (r_cnt == '0))) begin
            r_cnt <= LOAD;
        end else if (i_run) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign o_bit_end     = i_run && (r_cnt == '0);
    assign o_bit_pre_end = i_run && (r_cnt == CW'(1));

endmodule

// File: rtl/mp_link_tx.sv
// Framed idle-high serial sender of local pause/reload/score to the peer board.
// Latency: trigger in IDLE at cycle N drives start bit from N+1; frame 8 or 9 bit times.
// Backpressure: none; input changes and send_now during a frame are deferred to next IDLE.
// Ports: clk, rst (sync active-high), new_frame (keepalive tick), pause, reload,
//        score[3:0], send_now (force frame), tx_line (idle high), busy,
//        frame_done (last cycle of stop bit).
// Build option: define MP_LINK_PARITY_EN to insert an even-parity bit after the payload.
// CLKS_PER_BIT must be at least 2 so frame_done can be registered ahead of the last cycle.
module mp_link_tx
    import mp_link_pkg::*;
#(
    parameter int CLKS_PER_BIT     = 564,
    parameter int KEEPALIVE_FRAMES = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       new_frame,
    input  logic       pause,
    input  logic       reload,
    input  logic [3:0] score,
    input  logic       send_now,
    output logic       tx_line,
    output logic       busy,
    output logic       frame_done
);

    localparam int KW = $clog2(KEEPALIVE_FRAMES + 1);
    localparam logic [KW-1:0] KA_MAX = KW'(KEEPALIVE_FRAMES);
    localparam logic [2:0] LAST_IDX = 3'(MP_PAYLOAD_BITS - 1);

    mp_state_t   r_state, w_state_nxt;
    mp_payload_t w_payload, r_last_sent;
    logic [MP_PAYLOAD_BITS-1:0] r_shift;
    logic [2:0]  r_bit_idx;
    logic [KW-1:0] r_ka_cnt;
    logic        r_pending_init, r_pending_send;
    logic        r_tx, r_busy, r_frame_done;
    logic        w_tx_nxt, w_busy_nxt, w_frame_done_nxt;
    logic        w_trigger, w_run, w_bit_end, w_bit_pre_end;
`ifdef MP_LINK_PARITY_EN
    logic        r_parity;
`endif

    assign w_payload = mp_payload_t'({score, reload, pause});
    assign w_run     = (r_state != ST_IDLE);

    assign w_trigger = (r_state == ST_IDLE) &&
                       ((w_payload != r_last_sent) || send_now || r_pending_send ||
                        (r_ka_cnt == KA_MAX) || r_pending_init);

    mp_link_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk           (clk),
        .rst           (rst),
        .i_start       (w_trigger),
        .i_run         (w_run),
        .o_bit_end     (w_bit_end),
        .o_bit_pre_end (w_bit_pre_end)
    );

    // Next-state and next-output logic; outputs are registered below so the
    // line level changes on the same edge as the state.
    always_comb begin
        w_state_nxt      = r_state;
        w_tx_nxt         = r_tx;
        w_busy_nxt       = r_busy;
        w_frame_done_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_tx_nxt   = 1'b1;
                w_busy_nxt = 1'b0;
                if (w_trigger) begin
                    w_state_nxt = ST_START;
                    w_tx_nxt    = 1'b0;
                    w_busy_nxt  = 1'b1;
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_state_nxt = ST_DATA;
                    w_tx_nxt    = r_shift[0];
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    if (r_bit_idx == LAST_IDX) begin
`ifdef MP_LINK_PARITY_EN
                        w_state_nxt = ST_PARITY;
                        w_tx_nxt    = r_parity;
`else
                        w_state_nxt = ST_STOP;
                        w_tx_nxt    = 1'b1;
`endif
                    end else begin
                        // Shift register advances on this edge; present the next bit now.
                        w_tx_nxt = r_shift[1];
                    end
                end
            end
            ST_PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = ST_STOP;
                    w_tx_nxt    = 1'b1;
                end
            end
            ST_STOP: begin
                // Registered one cycle early so it lands on the final stop cycle.
                w_frame_done_nxt = w_bit_pre_end;
                if (w_bit_end) begin
                    w_state_nxt = ST_IDLE;
                    w_tx_nxt    = 1'b1;
                    w_busy_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_tx_nxt    = 1'b1;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_tx         <= 1'b1;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_tx         <= w_tx_nxt;
            r_busy       <= w_busy_nxt;
            r_frame_done <= w_frame_done_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_sent    <= '0;
            r_shift        <= '0;
            r_bit_idx      <= '0;
            r_ka_cnt       <= '0;
            r_pending_init <= 1'b1;
            r_pending_send <= 1'b0;
`ifdef MP_LINK_PARITY_EN
            r_parity       <= 1'b0;
`endif
        end else if (w_trigger) begin
            r_shift        <= w_payload;
            r_last_sent    <= w_payload;
            r_bit_idx      <= '0;
            r_ka_cnt       <= '0;
            r_pending_init <= 1'b0;
            r_pending_send <= 1'b0;
`ifdef MP_LINK_PARITY_EN
            r_parity       <= mp_parity(w_payload);
`endif
        end else begin
            if ((r_state == ST_DATA) && w_bit_end) begin
                r_shift   <= r_shift >> 1;
                r_bit_idx <= r_bit_idx + 3'd1;
            end
            // Any number of requests during a frame collapse into one follow-up frame.
            if (send_now && w_run) begin
                r_pending_send <= 1'b1;
            end
            if (new_frame && !w_run && (r_ka_cnt != KA_MAX)) begin
                r_ka_cnt <= r_ka_cnt + KW'(1);
            end
        end
    end

    assign tx_line    = r_tx;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_mp_link_tx.sv
// Directed plus randomized check of mp_link_tx against a frame-level reference model.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_mp_link_tx;
    import mp_link_pkg::*;

    localparam int C = 4;
    localparam int K = 3;
`ifdef MP_LINK_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif
    localparam int L = NB * C;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       new_frame = 1'b0;
    logic       pause = 1'b0;
    logic       reload = 1'b0;
    logic [3:0] score = 4'd0;
    logic       send_now = 1'b0;
    logic       tx_line, busy, frame_done;

    int checks = 0;
    int errors = 0;
    logic [5:0] model_last;

    mp_link_tx #(
        .CLKS_PER_BIT     (C),
        .KEEPALIVE_FRAMES (K)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .new_frame  (new_frame),
        .pause      (pause),
        .reload     (reload),
        .score      (score),
        .send_now   (send_now),
        .tx_line    (tx_line),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Line level during each bit time of a frame carrying payload p.
    function automatic logic [8:0] frame_bits(input logic [5:0] p);
        logic [8:0] fb;
        fb    = '1;
        fb[0] = 1'b0;
        for (int i = 0; i < 6; i++) fb[1+i] = p[i];
`ifdef MP_LINK_PARITY_EN
        fb[7] = ^p;
        fb[8] = 1'b1;
`else
        fb[7] = 1'b1;
`endif
        return fb;
    endfunction

    // One cycle; one-cycle pulses driven on the previous step end here.
    task automatic tick();
        @(negedge clk);
        send_now  = 1'b0;
        new_frame = 1'b0;
    endtask

    task automatic set_payload(input logic [5:0] p);
        {score, reload, pause} = p;
    endtask

    task automatic expect_idle(input string tag, input int n);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (tx_line !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) bad++;
        end
        check(tag, 64'(bad), 64'd0);
    endtask

    task automatic wait_start(input string tag, input int exp_lat, output bit ok);
        int lat;
        lat = 0;
        ok  = 1'b0;
        while (!ok && lat < exp_lat + 3 * L) begin
            tick();
            lat++;
            if (tx_line === 1'b0) ok = 1'b1;
        end
        check({tag, " start latency"}, 64'(lat), 64'(exp_lat));
    endtask

    // act: 0 none, 1 payload change at act_cyc, 2 send_now at act_cyc and +6,
    //      3 new_frame at act_cyc, +6 and +12.
    task automatic capture(input string tag, input logic [5:0] p, input int act,
                           input int act_cyc, input logic [5:0] new_p);
        logic [8:0]   fb;
        logic [C-1:0] smp [NB];
        int           fd_cnt, fd_pos, busy_bad;
        fb = frame_bits(p);
        fd_cnt = 0; fd_pos = -1; busy_bad = 0;
        for (int cyc = 0; cyc < L; cyc++) begin
            if (cyc > 0) tick();
            smp[cyc / C][cyc % C] = tx_line;
            if (busy !== 1'b1) busy_bad++;
            if (frame_done === 1'b1) begin
                fd_cnt++;
                fd_pos = cyc;
            end
            if (act == 1 && cyc == act_cyc) set_payload(new_p);
            if (act == 2 && (cyc == act_cyc || cyc == act_cyc + 6)) send_now = 1'b1;
            if (act == 3 && (cyc == act_cyc || cyc == act_cyc + 6 || cyc == act_cyc + 12))
                new_frame = 1'b1;
        end
        for (int b = 0; b < NB; b++)
            check($sformatf("%s bit%0d", tag, b), 64'(smp[b]), 64'({C{fb[b]}}));
        check({tag, " busy held"}, 64'(busy_bad), 64'd0);
        check({tag, " frame_done count"}, 64'(fd_cnt), 64'd1);
        check({tag, " frame_done pos"}, 64'(fd_pos), 64'(L - 1));
    endtask

    task automatic frame(input string tag, input logic [5:0] p, input int exp_lat,
                         input int act, input int act_cyc, input logic [5:0] new_p);
        bit ok;
        wait_start(tag, exp_lat, ok);
        if (ok) capture(tag, p, act, act_cyc, new_p);
    endtask

    initial begin
        logic [5:0] np, q;
        bit         chg;
        int         cyc;

        // Reset state
        repeat (3) tick();
        check("rst tx_line", 64'(tx_line), 64'd1);
        check("rst busy", 64'(busy), 64'd0);
        check("rst frame_done", 64'(frame_done), 64'd0);

        // First frame forced after reset, all-zero payload
        rst = 1'b0;
        model_last = 6'b0;
        frame("init", model_last, 1, 0, 0, 6'b0);
        expect_idle("init quiet", 20);

        // pause=1, score=1011; score changes to 5 in the middle of the frame
        np = {4'b1011, 1'b0, 1'b1};
        q  = {4'd5, 1'b0, 1'b1};
        set_payload(np);
        frame("p101101", np, 1, 1, 2 * C + 1, q);
        expect_idle("gap after p101101", 1);
        // new_frame pulses while busy must not advance the keepalive count
        frame("score5", q, 1, 3, 4, 6'b0);
        model_last = q;
        expect_idle("score5 quiet", 10);

        // Keepalive: third idle new_frame forces a repeat of last_sent
        new_frame = 1'b1;
        expect_idle("ka after 1", 3);
        new_frame = 1'b1;
        expect_idle("ka after 2", 10);
        new_frame = 1'b1;
        frame("keepalive", model_last, 2, 0, 0, 6'b0);
        expect_idle("keepalive quiet", 10);

        // Reset during DATA aborts the frame, then a fresh frame follows
        send_now = 1'b1;
        begin
            bit ok;
            wait_start("pre-reset", 1, ok);
        end
        repeat (C + 2) tick();
        rst = 1'b1;
        tick();
        check("midrst tx_line", 64'(tx_line), 64'd1);
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst frame_done", 64'(frame_done), 64'd0);
        tick();
        rst = 1'b0;
        frame("post-reset", model_last, 1, 0, 0, 6'b0);
        expect_idle("post-reset quiet", 10);

        // Two send_now pulses during a frame give exactly one extra frame
        send_now = 1'b1;
        frame("sn first", model_last, 1, 2, 5, 6'b0);
        expect_idle("sn gap", 1);
        frame("sn extra", model_last, 1, 0, 0, 6'b0);
        expect_idle("sn quiet", 20);

        // Randomized payloads, optional coincident send_now, optional mid-frame change
        for (int it = 0; it < 6; it++) begin
            np = model_last;
            while (np == model_last) np = 6'($urandom);
            q   = 6'($urandom);
            chg = 1'($urandom_range(0, 1));
            cyc = $urandom_range(1, L - 2);
            set_payload(np);
            send_now = 1'($urandom_range(0, 1));
            frame($sformatf("rnd%0d", it), np, 1, chg ? 1 : 0, cyc, q);
            model_last = np;
            if (chg && q != np) begin
                expect_idle($sformatf("rnd%0d gap", it), 1);
                frame($sformatf("rnd%0d chg", it), q, 1, 0, 0, 6'b0);
                model_last = q;
            end
            expect_idle($sformatf("rnd%0d quiet", it), 12);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mp_link_tx.md
# mp_link_tx

Serial transmitter for the two-board multiplayer link. It samples the local player's status (pause, reload, 4-bit score) and sends it to the peer board as a framed, idle-high, single-wire serial word. It sits in the control section beside the pause/reload/score controllers. It drives the pin that the peer board's debounced player-2 receive path samples, so this block is the sending end of the existing player-2 input path.

## Interface
Parameters:
- CLKS_PER_BIT, 564, clock cycles per bit time (65 MHz / 115200 baud).
- KEEPALIVE_FRAMES, 30, count of `new_frame` pulses without a transmission before a frame is forced.

Ports:
- clk  input  1  main 65 MHz clock; one clock domain only.
- rst  input  1  synchronous, active-high reset.
- new_frame  input  1  one-cycle VGA frame-start pulse; used only for keepalive.
- pause  input  1  local pause level.
- reload  input  1  local reload level.
- score  input  4  local score counter.
- send_now  input  1  one-cycle request to force a frame.
- tx_line  output  1  serial line; idle high.
- busy  output  1  high while a frame is on the line.
- frame_done  output  1  one-cycle pulse on the final cycle of the stop bit.

## Operation
- Payload is 6 bits: bit0 `pause`, bit1 `reload`, bits5:2 `score`.
- Frame order: start bit (0), payload bits LSB first, optional even-parity bit, stop bit (1).
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START when a trigger is seen.
  - START -> DATA after 1 bit time.
  - DATA -> PARITY after 6 bit times (bit index 0..5).
  - PARITY -> STOP after 1 bit time.
  - STOP -> IDLE after 1 bit time.
- Trigger is evaluated in IDLE only. It is the OR of:
  - the live payload differs from `last_sent`;
  - `send_now`;
  - the keepalive counter has reached KEEPALIVE_FRAMES;
  - the `pending_init` flag is set.
- On a trigger, the live payload is latched into the shift register and into `last_sent`. The keepalive counter clears and `pending_init` clears.
- Input changes during a frame are not sampled. After returning to IDLE, the difference from `last_sent` produces the next frame.
- A `send_now` pulse arriving while busy is held in a single pending flag and serviced at the next IDLE. Several pulses collapse into one frame.
- Keepalive counter: increments on `new_frame` while not busy and saturates at KEEPALIVE_FRAMES. A `new_frame` during busy is ignored.
- Parity bit is the XOR of the 6 payload bits, which gives even parity over payload plus parity.

## Timing
- Reset values:
  - `tx_line`=1, `busy`=0, `frame_done`=0.
  - FSM in IDLE.
  - `last_sent`=0, keepalive counter=0.
  - `pending_init`=1, so the first frame is sent automatically after reset.
- All outputs are registered. A trigger in IDLE at cycle N gives `tx_line`=0 and `busy`=1 from cycle N+1.
- Every bit lasts exactly CLKS_PER_BIT cycles. A frame is 9×CLKS_PER_BIT cycles with parity and 8×CLKS_PER_BIT without.
- `frame_done` is high on the last cycle of STOP. `busy` falls on the following cycle with IDLE re-entered.
- Minimum gap between frames is 1 idle cycle (line high). Back-to-back frames therefore have stop bit + 1 cycle of high level.
- Reset asserted mid-frame: on the next edge, `tx_line`=1 and all state returns to reset values. The truncated frame is not resumed, and a fresh frame follows because `pending_init` is set.
- `send_now` coincident with a payload change in IDLE produces a single frame.

## Configuration
- `MP_LINK_PARITY_EN` defined: the PARITY state is present and the frame is 9 bit times.
- `MP_LINK_PARITY_EN` not defined: DATA goes directly to STOP and the frame is 8 bit times. The receiver must be built with the same setting.

## Structure
- Package `mp_link_pkg` holds:
  - `mp_payload_t`, a packed struct {score[3:0], reload, pause};
  - the FSM state enum;
  - `MP_PAYLOAD_BITS`=6;
  - frame-length constants for both parity settings.
- One sub-module, `mp_link_bit_timer`. It is a CLKS_PER_BIT down-counter with a `start` load input and a `bit_end` one-cycle tick output. The FSM advances only on `bit_end`.

## Test plan
All scenarios use CLKS_PER_BIT=4 and KEEPALIVE_FRAMES=3.
- Release reset with pause=0, reload=0, score=0 -> one frame 0,000000,0,1 (36 cycles), `frame_done` once, then the line stays high.
- Set score=4'b1011, pause=1 while idle -> payload 101101 sent LSB first as 1,0,1,1,0,1, with parity bit 0 and correct bit widths.
- Change score to 5 mid-frame -> the current frame completes unchanged, then a second frame carries score 5 after exactly 1 idle cycle.
- Hold inputs stable and pulse `new_frame` 3 times while idle -> a keepalive frame repeats `last_sent`. `new_frame` pulses during busy do not count.
- Assert `rst` during DATA -> `tx_line`=1 and `busy`=0 on the next edge, then a full fresh frame after release.
- Pulse `send_now` twice during a frame -> exactly one extra frame follows. Without `MP_LINK_PARITY_EN`, each frame is 32 cycles.
